ads_touch_spi: RTL and testbench



---
 rtl/ads_touch_spi.sv | 197 +++++++++++++++++++
 tb/tb_ads_touch_spi.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ads_touch_spi.sv
// ads_touch_spi: ADS7843 touch-controller SPI master behind an Avalon-MM slave (8-bit command, 12-bit result).
// Optional macro ADS_BUSY_WAIT_EN inserts a BUSY-pulse wait (with timeout) between the command and result phases.
module ads_touch_spi #(
  parameter int CLK_DIV      = 25,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ads_cs_n,
  output logic        ads_dclk,
  output logic        ads_din,
  input  logic        ads_dout,
  input  logic        ads_busy,
  input  logic        ads_penirq_n
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

`ifdef ADS_BUSY_WAIT_EN
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_BWAIT, S_DONE} state_t;
  localparam logic [15:0] WAIT_LAST = 16'(BUSY_TIMEOUT - 1);
  logic [1:0]  busy_sync_q, busy_sync_d;
  logic [15:0] wait_q, wait_d;
  logic        seen_q, seen_d;
  logic        unused_cfg;
  assign unused_cfg = ^writedata[31:8];
`else
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE} state_t;
  logic unused_cfg;
  assign unused_cfg = ^{ads_busy, writedata[31:8], 16'(BUSY_TIMEOUT)};
`endif

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic        dclk_q, dclk_d;
  logic        cs_n_q, cs_n_d;
  logic        din_q, din_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [11:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] readdata_q, readdata_d;
  logic [1:0]  dout_sync_q, dout_sync_d;
  logic [1:0]  pen_sync_q, pen_sync_d;

  assign readdata = readdata_q;
  assign ads_cs_n = cs_n_q;
  assign ads_dclk = dclk_q;
  assign ads_din  = din_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    dclk_d      = dclk_q;
    cs_n_d      = cs_n_q;
    din_d       = din_q;
    cmd_d       = cmd_q;
    result_d    = result_q;
    done_d      = done_q;
    err_d       = err_q;
    dout_sync_d = {dout_sync_q[0], ads_dout};
    pen_sync_d  = {pen_sync_q[0], ads_penirq_n};
`ifdef ADS_BUSY_WAIT_EN
    busy_sync_d = {busy_sync_q[0], ads_busy};
    wait_d      = wait_q;
    seen_d      = seen_q;
`endif

    // Done-clear happens first so both a start and the DONE state override it.
    if (read && address == 2'd2) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (write && address == 2'd1) begin
          cmd_d   = writedata[7:0];
          din_d   = writedata[7];
          done_d  = 1'b0;
          err_d   = 1'b0;
          cs_n_d  = 1'b0;
          dclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!dclk_q) begin
            dclk_d = 1'b1;
            if (bit_q >= 5'd9 && bit_q <= 5'd20) result_d = {result_q[10:0], dout_sync_q[1]};
          end else begin
            dclk_d = 1'b0;
            if (bit_q == 5'd23) begin
              state_d = S_DONE;
            end else begin
              bit_d = bit_q + 5'd1;
              din_d = (bit_q < 5'd7) ? cmd_q[3'd6 - bit_q[2:0]] : 1'b0;
`ifdef ADS_BUSY_WAIT_EN
              if (bit_q == 5'd7) begin
                state_d = S_BWAIT;
                wait_d  = '0;
                seen_d  = 1'b0;
              end
`endif
            end
          end
        end
      end
`ifdef ADS_BUSY_WAIT_EN
      S_BWAIT: begin
        // dclk stays low and div is already zero, so SHIFT resumes with period 8's low half.
        wait_d = wait_q + 16'd1;
        if (busy_sync_q[1]) seen_d = 1'b1;
        if (seen_q && !busy_sync_q[1]) begin
          state_d = S_SHIFT;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_SHIFT;
        end
      end
`endif
      S_DONE: begin
        cs_n_d  = 1'b1;
        done_d  = 1'b1;
        din_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (address)
      2'd0:    readdata_d = {28'd0, err_q, ~pen_sync_q[1], done_q, state_q != S_IDLE};
      2'd1:    readdata_d = {24'd0, cmd_q};
      2'd2:    readdata_d = {20'd0, result_q};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      dclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      din_q       <= 1'b0;
      cmd_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      readdata_q  <= '0;
      dout_sync_q <= '0;
      pen_sync_q  <= 2'b11;
`ifdef ADS_BUSY_WAIT_EN
      busy_sync_q <= '0;
      wait_q      <= '0;
      seen_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      dclk_q      <= dclk_d;
      cs_n_q      <= cs_n_d;
      din_q       <= din_d;
      cmd_q       <= cmd_d;
      result_q    <= result_d;
      done_q      <= done_d;
      err_q       <= err_d;
      readdata_q  <= readdata_d;
      dout_sync_q <= dout_sync_d;
      pen_sync_q  <= pen_sync_d;
`ifdef ADS_BUSY_WAIT_EN
      busy_sync_q <= busy_sync_d;
      wait_q      <= wait_d;
      seen_q      <= seen_d;
`endif
    end
  end
endmodule

// File: tb/tb_ads_touch_spi.sv
// Scoreboard bench for ads_touch_spi: reads queue expected readdata, a monitor pops and compares.
module tb_ads_touch_spi;
  localparam int CLK_DIV = 25;

  logic        clk = 1'b0;
  logic        reset, read, write;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        ads_cs_n, ads_dclk, ads_din, ads_dout, ads_busy, ads_penirq_n;

  ads_touch_spi #(.CLK_DIV(CLK_DIV), .BUSY_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .ads_cs_n(ads_cs_n), .ads_dclk(ads_dclk),
    .ads_din(ads_din), .ads_dout(ads_dout), .ads_busy(ads_busy), .ads_penirq_n(ads_penirq_n)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [31:0] exp; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a transaction spans start + setup + 24 full dclk periods + done cycle.
  int txn_len = 1 + CLK_DIV + 48 * CLK_DIV + 1;
  logic [7:0]  cmd_m;
  logic [11:0] dev_val;
  int fall_n, rises, last_rises;
  logic [7:0] din_byte, last_byte;
  logic prev_dclk, prev_cs;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic issue_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    address = a;
    read    = 1'b1;
    sb_q.push_back('{nm, exp});
  endtask

  task automatic strobes_off();
    read  = 1'b0;
    write = 1'b0;
  endtask

  // Monitor: every read strobe yields a registered readdata one edge later.
  initial forever begin
    @(posedge clk);
    if (read) begin
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: readdata 0x%08h, expected no read", readdata);
      end else begin
        mon_e = sb_q.pop_front();
        check(mon_e.name, readdata, mon_e.exp);
      end
    end
  end

  // ADS7843 model: new dout bit after each dclk fall, din captured on the first 8 rises.
  initial begin
    ads_dout = 1'b0; fall_n = 0; rises = 0; din_byte = '0;
    prev_dclk = 1'b0; prev_cs = 1'b1; last_rises = 0; last_byte = '0;
    forever begin
      @(posedge clk);
      #2;
      if (ads_cs_n) begin
        if (!prev_cs) begin
          last_rises = rises;
          last_byte  = din_byte;
        end
        fall_n = 0; rises = 0; din_byte = '0; ads_dout = 1'b0;
      end else if (prev_dclk && !ads_dclk) begin
        fall_n++;
        ads_dout = (fall_n >= 9 && fall_n <= 20) ? dev_val[20 - fall_n] : 1'b0;
      end else if (!prev_dclk && ads_dclk) begin
        rises++;
        if (rises <= 8) din_byte = {din_byte[6:0], ads_din};
      end
      prev_dclk = ads_dclk;
      prev_cs   = ads_cs_n;
    end
  end

  task automatic run_txn(input logic [7:0] c, input logic [11:0] v, input bit inject);
    dev_val = v;
    @(negedge clk);
    strobes_off();
    writedata = ($urandom() & 32'hFFFF_FF00) | 32'(c);
    write = 1'b1;
    issue_read(2'd1, 32'(cmd_m), "cmd_prev_on_start");
    cmd_m = c;
    for (int j = 1; j <= txn_len + 2; j++) begin
      @(negedge clk);
      strobes_off();
      if (j == 1) begin
        check("cs_n_asserted", 32'(ads_cs_n), 32'd0);
        issue_read(2'd1, 32'(c), "cmd_latched");
      end
      if (j == 2) issue_read(2'd0, 32'h1, "status_active");
      if (inject && j == 100) begin
        writedata = $urandom();
        write = 1'b1;
        issue_read(2'd1, 32'(c), "cmd_ignore_same_cycle");
      end
      if (j == 101) issue_read(2'd1, 32'(c), "cmd_after_ignored_write");
      if (j == txn_len - 1) begin
        check("cs_n_before_done", 32'(ads_cs_n), 32'd0);
        issue_read(2'd0, 32'h1, "status_before_done");
      end
      if (j == txn_len) begin
        check("cs_n_after_done", 32'(ads_cs_n), 32'd1);
        issue_read(2'd0, 32'h2, "status_done");
      end
      if (j == txn_len + 1) issue_read(2'd2, 32'(v), "result");
      if (j == txn_len + 2) issue_read(2'd0, 32'h0, "status_done_cleared");
    end
    @(negedge clk);
    strobes_off();
    check("din_cmd_byte", 32'(last_byte), 32'(c));
    check("dclk_rises", 32'(last_rises), 32'd24);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    ads_busy = 1'b0; ads_penirq_n = 1'b1; cmd_m = '0; dev_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(ads_cs_n), 32'd1);
    check("rst_dclk", 32'(ads_dclk), 32'd0);
    check("rst_din", 32'(ads_din), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      strobes_off();
      issue_read(2'(a), 32'd0, "rst_reg");
    end

    // Pen-down path: two sync flops plus the registered read.
    @(negedge clk); ads_penirq_n = 1'b0; issue_read(2'd0, 32'h0, "pen_lat1");
    @(negedge clk); issue_read(2'd0, 32'h0, "pen_lat2");
    @(negedge clk); issue_read(2'd0, 32'h4, "pen_down");
    @(negedge clk); ads_penirq_n = 1'b1; issue_read(2'd0, 32'h4, "pen_rel1");
    @(negedge clk); issue_read(2'd0, 32'h4, "pen_rel2");
    @(negedge clk); issue_read(2'd0, 32'h0, "pen_up");

    // Writes to other addresses do nothing.
    for (int a = 0; a < 4; a++) begin
      if (a == 1) continue;
      @(negedge clk);
      strobes_off();
      address = 2'(a);
      writedata = $urandom();
      write = 1'b1;
    end
    @(negedge clk); strobes_off(); issue_read(2'd0, 32'h0, "status_after_stray_writes");
    @(negedge clk); issue_read(2'd1, 32'h0, "cmd_after_stray_writes");
    @(negedge clk); strobes_off();

    run_txn(8'h90, 12'hA5C, 1'b1);
    for (int t = 0; t < 3; t++)
      run_txn(8'($urandom_range(0, 255)), 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));

    // Reset deep in SHIFT after several result bits have been captured.
    dev_val = 12'hFFF;
    @(negedge clk);
    address = 2'd1; writedata = 32'h0000_00B3; write = 1'b1;
    @(negedge clk); strobes_off();
    repeat (799) @(negedge clk);
    check("cs_n_mid_shift", 32'(ads_cs_n), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_cs_n", 32'(ads_cs_n), 32'd1);
    check("midrst_dclk", 32'(ads_dclk), 32'd0);
    check("midrst_din", 32'(ads_din), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); issue_read(2'd0, 32'h0, "midrst_status");
    @(negedge clk); issue_read(2'd2, 32'h0, "midrst_result");
    @(negedge clk); strobes_off();

    // Reset coinciding with a start write.
    @(negedge clk);
    reset = 1'b1; address = 2'd1; writedata = 32'h90; write = 1'b1;
    @(posedge clk); #1;
    check("rst_start_cs_n", 32'(ads_cs_n), 32'd1);
    @(negedge clk); reset = 1'b0; strobes_off();
    @(posedge clk); #1;
    check("rst_start_cs_n_after", 32'(ads_cs_n), 32'd1);
    @(negedge clk); issue_read(2'd0, 32'h0, "rst_start_status");
    @(negedge clk); strobes_off();

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
